// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Bundle of opcode/status inputs and control strobes exchanged
//            between the multi-cycle control unit and its datapath/memory.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                memReady;
  logic                instrRead;
  logic                irWrite;
  logic                pcWrite;
  logic                jump;
  logic                branch;
  logic [ALUOP_W-1:0]  aluOp;
  logic                regWrite;
  logic                memRead;
  logic                memWrite;
  logic                halted;
  logic                illegalOp;
  logic                memTimeout;
  logic [2:0]          state;
  logic [CNT_W-1:0]    instrCount;

  // Control unit side: consumes opcode/status, drives every strobe.
  modport master (
    input  opcode, zero, memReady,
    output instrRead, irWrite, pcWrite, jump, branch, aluOp, regWrite,
           memRead, memWrite, halted, illegalOp, memTimeout, state, instrCount
  );

  // Datapath/memory side.
  modport slave (
    output opcode, zero, memReady,
    input  instrRead, irWrite, pcWrite, jump, branch, aluOp, regWrite,
           memRead, memWrite, halted, illegalOp, memTimeout, state, instrCount
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Multi-cycle instruction sequencer (FETCH/DECODE/EXECUTE/MEM/
//            WRITEBACK/HALT) with memory handshake, MEM wait timeout,
//            retired-instruction counter and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.master bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_HALT  = {OPCODE_W{1'b1}};

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t              state_reg, next_state;
  logic [OPCODE_W-1:0] op_reg;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    count_reg;
  logic                illegal_reg, timeout_reg;

  logic instr_read, ir_write, pc_write, jump_sel, branch_sel, alu_sub;
  logic reg_write, mem_read, mem_write;
  logic count_inc, set_illegal, set_timeout;

  // State, opcode latch, MEM wait counter, retire counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      op_reg      <= '0;
      wait_cnt    <= '0;
      count_reg   <= '0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= next_state;
      if (state_reg == S_DECODE) begin
        op_reg <= bus.opcode;
      end
      // Held at zero outside MEM so every MEM visit starts from a clean count.
      if (state_reg != S_MEM) begin
        wait_cnt <= '0;
      end else if (!bus.memReady) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (count_inc) begin
        count_reg <= count_reg + 1'b1;
      end
      if (set_illegal) begin
        illegal_reg <= 1'b1;
      end
      if (set_timeout) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode from state, opcode, zero and memReady.
  always_comb begin
    next_state  = state_reg;
    instr_read  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    jump_sel    = 1'b0;
    branch_sel  = 1'b0;
    alu_sub     = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    count_inc   = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_reg)
      S_FETCH: begin
        instr_read = 1'b1;
        if (bus.memReady) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      // The live opcode is decoded here; it is latched at the end of this cycle.
      S_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_BEQ: next_state = S_EXECUTE;
          OP_JUMP: begin
            pc_write   = 1'b1;
            jump_sel   = 1'b1;
            count_inc  = 1'b1;
            next_state = S_FETCH;
          end
          OP_HALT: next_state = S_HALT;
          default: begin
            set_illegal = 1'b1;
            next_state  = S_FETCH;
          end
        endcase
      end
      S_EXECUTE: begin
        alu_sub = (op_reg == OP_SUB) || (op_reg == OP_BEQ);
        if (op_reg == OP_LOAD || op_reg == OP_STORE) begin
          next_state = S_MEM;
        end else if (op_reg == OP_BEQ) begin
          branch_sel = 1'b1;
          pc_write   = bus.zero;
          count_inc  = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_WRITEBACK;
        end
      end
      // Completion on memReady takes priority over the timeout check.
      S_MEM: begin
        mem_read  = (op_reg == OP_LOAD);
        mem_write = (op_reg != OP_LOAD);
        if (bus.memReady) begin
          if (op_reg == OP_LOAD) begin
            next_state = S_WRITEBACK;
          end else begin
            count_inc  = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          next_state  = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        count_inc  = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is asserted.
  assign bus.instrRead  = instr_read & ~reset;
  assign bus.irWrite    = ir_write   & ~reset;
  assign bus.pcWrite    = pc_write   & ~reset;
  assign bus.jump       = jump_sel   & ~reset;
  assign bus.branch     = branch_sel & ~reset;
  assign bus.aluOp      = (alu_sub & ~reset) ? ALUOP_W'(1) : '0;
  assign bus.regWrite   = reg_write  & ~reset;
  assign bus.memRead    = mem_read   & ~reset;
  assign bus.memWrite   = mem_write  & ~reset;
  assign bus.halted     = (state_reg == S_HALT) & ~reset;
  assign bus.illegalOp  = illegal_reg;
  assign bus.memTimeout = timeout_reg;
  assign bus.state      = state_reg;
  assign bus.instrCount = count_reg;

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. It handshakes with memory via memReady, supports conditional branch and halt, and keeps a retired-instruction counter plus sticky error flags. It sits between the instruction register/datapath and the memory interface.

Parameters:
OPCODE_W, 4, opcode width; must be >= 4; HALT opcode is all-ones.
ALUOP_W, 2, aluOp width; must be >= 2; codes are zero-extended.
MEM_TIMEOUT, 15, consecutive memReady-low cycles in MEM before abort; must be >= 1.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  OPCODE_W  opcode field of the instruction register
zero  input  1  ALU zero flag, valid in EXECUTE
memReady  input  1  memory completes the current fetch/read/write this cycle
instrRead  output  1  instruction fetch request
irWrite  output  1  load instruction register
pcWrite  output  1  update PC
jump  output  1  PC source = jump target (qualifies pcWrite)
branch  output  1  PC source = branch target (qualifies pcWrite)
aluOp  output  ALUOP_W  0 = add, 1 = sub
regWrite  output  1  register file write strobe
memRead  output  1  data read request
memWrite  output  1  data write request
halted  output  1  core halted
illegalOp  output  1  sticky: undefined opcode decoded
memTimeout  output  1  sticky: MEM wait exceeded MEM_TIMEOUT
state  output  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5
instrCount  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Clock and reset ports are clk and reset.
- Reset (async, any state, including mid-MEM):
  - state=FETCH; internal opcode latch=0; wait counter=0; instrCount=0; illegalOp=0; memTimeout=0.
  - All strobes deassert immediately; aluOp=0; halted=0.
- Opcodes (zero-extended to OPCODE_W): 0 ADD, 1 SUB, 2 LOAD, 3 STORE, 4 JUMP, 5 BEQ, all-ones HALT. Every other value is illegal.
- Strobes are decoded from state, the latched opcode, zero and memReady. Only the stated strobes are high in a state; all others are 0.
- FETCH:
  - instrRead=1 throughout.
  - On memReady: irWrite=1 and pcWrite=1 (PC+1) in the same cycle; next state DECODE.
  - Waits indefinitely otherwise.
- DECODE (1 cycle): opcode is latched at the end of this cycle; later opcode changes are ignored.
  - ADD/SUB/LOAD/STORE/BEQ -> EXECUTE.
  - JUMP: pcWrite=1, jump=1, instrCount+1, -> FETCH.
  - HALT -> HALT.
  - Illegal: illegalOp set, no count, -> FETCH.
- EXECUTE (1 cycle): aluOp=1 for SUB/BEQ, otherwise 0.
  - ADD/SUB -> WRITEBACK.
  - LOAD/STORE -> MEM (address add).
  - BEQ: branch=1, pcWrite=zero, instrCount+1, -> FETCH.
- MEM: memRead=1 (LOAD) or memWrite=1 (STORE), held until memReady.
  - On memReady: LOAD -> WRITEBACK; STORE -> FETCH with instrCount+1.
  - Wait counter increments each memReady-low cycle and clears on entering MEM.
  - If memReady is low on the MEM_TIMEOUT-th consecutive cycle: memTimeout set, no count, -> FETCH next cycle.
  - If memReady rises on that same cycle, completion wins.
- WRITEBACK (1 cycle): regWrite=1, instrCount+1, -> FETCH.
- HALT: halted=1, all strobes 0, state holds until reset.
- Sticky flags clear only on reset. instrCount wraps from all-ones to 0 without any flag.
- Latency with memReady tied high, fetch to next FETCH: ADD/SUB 4, LOAD 5, STORE 4, BEQ 3, JUMP 2 cycles.

Test Plan:
- memReady=1, ADD then SUB -> states 0,1,2,4 per instruction. regWrite high in cycle 4. aluOp 0 then 1. instrCount=2 after 8 cycles.
- LOAD with memReady low for 3 MEM cycles, then high -> memRead held 4 cycles, then WRITEBACK regWrite=1, instrCount=1. STORE -> memWrite, no regWrite, 4 cycles.
- BEQ with zero=1 -> pcWrite=branch=1 in EXECUTE. Repeat with zero=0 -> branch=1, pcWrite=0. Both take 3 cycles. JUMP -> pcWrite=jump=1 in DECODE, 2 cycles.
- MEM_TIMEOUT=4, STORE with memReady held low -> memWrite for 4 cycles, memTimeout=1, then state=FETCH, instrCount unchanged. Next ADD executes normally.
- Opcode 4'b0111 -> illegalOp=1, FETCH after DECODE. Opcode 4'b1111 -> halted=1, state=5, held 20 cycles.
- Reset asserted mid-MEM during LOAD (memRead=1) -> memRead drops immediately, state=0, flags and instrCount=0. CNT_W=2 with 5 JUMPs -> instrCount=1.
